fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Instruction-fetch sequencer for the combinational instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned instruction, tagged with its PC, into a small FIFO fetch queue, and presents it to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- QDEPTH, 2, fetch-queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  out  32  byte address to the instruction ROM; equals the PC register.
- imem_rdata  in  32  instruction returned combinationally for imem_addr.
- fetch_en  in  1  1 = fetching permitted; 0 = freeze the PC, no pushes.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- q_count  out  $clog2(QDEPTH+1)  current queue occupancy.

Behaviour:
- Everything is clocked by the single clock clk. Reset is asynchronous and active-high on rst.
- Reset values: pc = RESET_PC; queue empty with read/write pointers 0; q_count = 0; out_valid = 0; out_instr = 0, out_pc = 0 (head storage cleared).
- imem_addr = pc, combinational from the register.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (q_count < QDEPTH | pop).
  - Push while full is legal only when a pop happens in the same cycle.
- On push: the entry {pc, imem_rdata} is written at the write pointer, and pc <= pc + 4.
  - PC arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- No push: pc holds and imem_addr is stable.
- Latency: an instruction pushed in cycle N appears at the head (out_valid = 1) in cycle N+1 when the queue was empty. There is no combinational bypass from imem_rdata to out_instr.
- q_count: next = q_count + push - pop. Simultaneous push and pop leaves it unchanged.
- Redirect (redirect_valid = 1) has highest priority:
  - The queue is flushed: pointers reset, q_count <= 0.
  - pc <= {redirect_pc[31:2], 2'b00}; misaligned target bits are silently cleared.
  - No push that cycle; any pop that cycle is discarded.
  - out_valid = 0 in cycle N+1.
  - The first instruction from the target is pushed in N+1 and visible in N+2.
- out_valid = (q_count != 0). out_instr/out_pc are driven from the head entry regardless; they are only meaningful while out_valid = 1.
- Stability: while out_valid = 1 and out_ready = 0, out_instr and out_pc must not change, except on redirect.
- fetch_en = 0: the queue still drains via pops. A redirect is still honoured (PC reload and flush).
- Pointers wrap modulo QDEPTH.
- Reset asserted mid-operation immediately returns all state to reset values, regardless of clock.

Test Plan:
- Reset release, fetch_en = 1, out_ready = 1 -> first cycle out_valid = 0; then one instruction per cycle:
  - out_pc = 0x00, out_instr = 32'h00500113
  - 0x04 / 32'h00700193
  - 0x08 / 32'h06310463, and so on.
- out_ready = 0 for 6 cycles after reset -> q_count saturates at 2 and pc/imem_addr hold at 0x08; head stays 0x00/32'h00500113. Releasing out_ready gives 0x00, 0x04, 0x08 in consecutive cycles with no gap or duplicate.
- Queue full (heads 0x00, 0x04), redirect_valid = 1 with redirect_pc = 0x23 -> next cycle out_valid = 0, q_count = 0, imem_addr = 0x20; following cycle out_pc = 0x20, out_instr = 32'h00a12223.
- Simultaneous redirect and pop in the same cycle -> the popped entry is the only one consumed, the flush wins, and no stale PC (0x04) is ever presented afterwards.
- RESET_PC = 32'hFFFF_FFFC, free-run -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004 (wrap).
- fetch_en dropped with 2 entries queued and out_ready = 1 -> both drain, then out_valid = 0 with pc frozen. rst pulsed asynchronously mid-stream -> out_valid = 0 and imem_addr = RESET_PC before the next clock edge.

Source files
------------

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer for a combinational instruction ROM. It owns
// the program counter, drives the ROM address from it, and captures each
// returned instruction (tagged with its PC) into a small FIFO fetch queue.
// Decode pulls instructions from the queue head over a valid/ready
// handshake. A branch/jump redirect from execute flushes the queue and
// reloads the PC.
//
// Parameters
//   RESET_PC       PC loaded on reset (word aligned)
//   QDEPTH         fetch-queue entries (power of two, >= 2)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   imem_addr      ROM byte address (equals the PC register)
//   imem_rdata     instruction returned combinationally for imem_addr
//   fetch_en       1 = fetching permitted, 0 = PC frozen and no pushes
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    redirect target byte address (low two bits ignored)
//   out_valid      queue head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction
//   out_pc         head PC
//   q_count        current queue occupancy
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    logic [31:0]   pc_reg;
    logic [31:0]   pc_next;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Queue storage. Kept in flops rather than RAM because the head is read
    // combinationally and the whole queue is cleared by reset.
    logic [31:0]   entry_pc_reg    [QDEPTH];
    logic [31:0]   entry_instr_reg [QDEPTH];

    logic          push;
    logic          pop;

    assign imem_addr = pc_reg;
    assign out_valid = (count_reg != '0);
    assign out_pc    = entry_pc_reg[rd_ptr_reg];
    assign out_instr = entry_instr_reg[rd_ptr_reg];
    assign q_count   = count_reg;

    assign pop  = out_valid & out_ready;
    // A full queue may still accept a push when the head leaves this cycle.
    assign push = fetch_en & ~redirect_valid & ((count_reg < QDEPTH_C) | pop);

    always_comb begin
        pc_next     = pc_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (redirect_valid) begin
            // Flush wins over any pop this cycle; target alignment bits dropped.
            pc_next     = {redirect_pc[31:2], 2'b00};
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                pc_next     = pc_reg + 32'd4;      // wraps modulo 2^32
                wr_ptr_next = wr_ptr_reg + PW'(1); // wraps modulo QDEPTH
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            pc_reg     <= pc_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                entry_pc_reg[i]    <= '0;
                entry_instr_reg[i] <= '0;
            end
        end else if (push) begin
            entry_pc_reg[wr_ptr_reg]    <= pc_reg;
            entry_instr_reg[wr_ptr_reg] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. DUT "a" uses RESET_PC = 0 and carries
// most of the scenarios; DUT "b" uses RESET_PC = FFFF_FFFC and free-runs to
// exercise PC wrap-around. A small ROM function supplies instructions.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] a_imem_addr, a_imem_rdata, a_out_instr, a_out_pc;
    logic        a_out_valid;
    logic [1:0]  a_q_count;

    logic [31:0] b_imem_addr, b_imem_rdata, b_out_instr, b_out_pc;
    logic        b_out_valid;
    logic [1:0]  b_q_count;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0050_0113;
            32'h0000_0004: rom = 32'h0070_0193;
            32'h0000_0008: rom = 32'h0631_0463;
            32'h0000_0020: rom = 32'h00a1_2223;
            default:       rom = {a[29:0], 2'b11};
        endcase
    endfunction

    assign a_imem_rdata = rom(a_imem_addr);
    assign b_imem_rdata = rom(b_imem_addr);

    fetch_controller #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (a_imem_addr),
        .imem_rdata     (a_imem_rdata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (a_out_valid),
        .out_ready      (out_ready),
        .out_instr      (a_out_instr),
        .out_pc         (a_out_pc),
        .q_count        (a_q_count)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (b_imem_addr),
        .imem_rdata     (b_imem_rdata),
        .fetch_en       (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (b_out_valid),
        .out_ready      (1'b1),
        .out_instr      (b_out_instr),
        .out_pc         (b_out_pc),
        .q_count        (b_q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        #12;
        check("rst_valid",  {31'd0, a_out_valid}, 32'd0);
        check("rst_count",  {30'd0, a_q_count},   32'd0);
        check("rst_addr",   a_imem_addr,          32'h0);
        check("rst_instr",  a_out_instr,          32'h0);
        check("rst_pc",     a_out_pc,             32'h0);
        check("rst_addr_b", b_imem_addr,          32'hFFFF_FFFC);

        // Free run: first cycle empty, then one instruction per cycle
        rst = 1'b0;
        check("run_first_valid", {31'd0, a_out_valid}, 32'd0);
        step();
        check("run0_valid", {31'd0, a_out_valid}, 32'd1);
        check("run0_pc",    a_out_pc,    32'h0000_0000);
        check("run0_instr", a_out_instr, 32'h0050_0113);
        check("wrap0_pc",   b_out_pc,    32'hFFFF_FFFC);
        step();
        check("run1_pc",    a_out_pc,    32'h0000_0004);
        check("run1_instr", a_out_instr, 32'h0070_0193);
        check("wrap1_pc",   b_out_pc,    32'h0000_0000);
        step();
        check("run2_pc",    a_out_pc,    32'h0000_0008);
        check("run2_instr", a_out_instr, 32'h0631_0463);
        check("run2_count", {30'd0, a_q_count}, 32'd1);
        check("wrap2_pc",   b_out_pc,    32'h0000_0004);

        // Asynchronous reset mid-stream, observed before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  {31'd0, a_out_valid}, 32'd0);
        check("arst_addr",   a_imem_addr, 32'h0);
        check("arst_count",  {30'd0, a_q_count}, 32'd0);
        check("arst_addr_b", b_imem_addr, 32'hFFFF_FFFC);

        // Back-pressure: queue saturates, PC holds
        out_ready = 1'b0;
        rst = 1'b0;
        repeat (6) step();
        check("bp_count", {30'd0, a_q_count}, 32'd2);
        check("bp_addr",  a_imem_addr, 32'h0000_0008);
        check("bp_pc",    a_out_pc,    32'h0000_0000);
        check("bp_instr", a_out_instr, 32'h0050_0113);
        out_ready = 1'b1;
        step();
        check("bp_rel1_valid", {31'd0, a_out_valid}, 32'd1);
        check("bp_rel1_pc",    a_out_pc, 32'h0000_0004);
        step();
        check("bp_rel2_valid", {31'd0, a_out_valid}, 32'd1);
        check("bp_rel2_pc",    a_out_pc,    32'h0000_0008);
        check("bp_rel2_instr", a_out_instr, 32'h0631_0463);

        // Redirect from a full queue to a misaligned target
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        check("rd_full_count", {30'd0, a_q_count}, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0023;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", {31'd0, a_out_valid}, 32'd0);
        check("rd_count", {30'd0, a_q_count},   32'd0);
        check("rd_addr",  a_imem_addr, 32'h0000_0020);
        step();
        check("rd_tgt_valid", {31'd0, a_out_valid}, 32'd1);
        check("rd_tgt_pc",    a_out_pc,    32'h0000_0020);
        check("rd_tgt_instr", a_out_instr, 32'h00a1_2223);

        // Redirect and pop in the same cycle: flush wins, no stale 0x04
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        check("rp_head_pc", a_out_pc, 32'h0000_0000);
        step();
        redirect_valid = 1'b0;
        check("rp_valid", {31'd0, a_out_valid}, 32'd0);
        check("rp_count", {30'd0, a_q_count},   32'd0);
        step();
        check("rp_tgt0_valid", {31'd0, a_out_valid}, 32'd1);
        check("rp_tgt0_pc",    a_out_pc, 32'h0000_0020);
        step();
        check("rp_tgt1_pc",    a_out_pc,    32'h0000_0024);
        check("rp_tgt1_instr", a_out_instr, rom(32'h0000_0024));

        // fetch_en dropped with two entries queued: drain, PC frozen
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fe_drain1_pc",    a_out_pc, 32'h0000_0004);
        check("fe_drain1_count", {30'd0, a_q_count}, 32'd1);
        step();
        check("fe_empty_valid", {31'd0, a_out_valid}, 32'd0);
        check("fe_empty_addr",  a_imem_addr, 32'h0000_0008);
        step();
        check("fe_hold_valid", {31'd0, a_out_valid}, 32'd0);
        check("fe_hold_addr",  a_imem_addr, 32'h0000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check("fe_rd_addr",  a_imem_addr, 32'h0000_0040);
        check("fe_rd_valid", {31'd0, a_out_valid}, 32'd0);
        step();
        check("fe_rd_hold_addr",  a_imem_addr, 32'h0000_0040);
        check("fe_rd_hold_valid", {31'd0, a_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
